// File: rtl/router_pkg.sv
// router_pkg: shared state encoding and width helper for the NUM_CH router controller
package router_pkg;

   typedef enum logic [3:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      LOAD_PARITY,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      WAIT_TILL_EMPTY,
      CHECK_PARITY_ERROR,
      DROP_PACKET
   } state_t;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if: control bundle between the router datapath blocks and the controller
//   i_pkt_valid     header/payload valid from source
//   i_parity_done   parity byte captured by register block
//   i_low_pkt_valid pkt_valid fell while FIFO was full
//   i_data_in       header address field
//   i_fifo_full     selected destination FIFO full
//   i_fifo_empty    per-channel FIFO empty
//   i_soft_reset    per-channel read-timeout soft reset
//   o_*             controller state flags, write request, destination, timeout pulse
//   master: datapath/source side, slave: controller side
interface router_fsm_nch_if #(
   parameter int NUM_CH = 3,
   parameter int ADDR_W = 2
);
   logic              i_pkt_valid;
   logic              i_parity_done;
   logic              i_low_pkt_valid;
   logic [ADDR_W-1:0] i_data_in;
   logic              i_fifo_full;
   logic [NUM_CH-1:0] i_fifo_empty;
   logic [NUM_CH-1:0] i_soft_reset;
   logic              o_busy;
   logic              o_detect_add;
   logic              o_lfd_state;
   logic              o_ld_state;
   logic              o_laf_state;
   logic              o_full_state;
   logic              o_write_enb_reg;
   logic              o_rst_int_reg;
   logic              o_drop_state;
   logic [ADDR_W-1:0] o_dest_sel;
   logic              o_timeout_err;

   modport master (
      output i_pkt_valid, i_parity_done, i_low_pkt_valid, i_data_in, i_fifo_full, i_fifo_empty, i_soft_reset,
      input  o_busy, o_detect_add, o_lfd_state, o_ld_state, o_laf_state, o_full_state,
             o_write_enb_reg, o_rst_int_reg, o_drop_state, o_dest_sel, o_timeout_err
   );

   modport slave (
      input  i_pkt_valid, i_parity_done, i_low_pkt_valid, i_data_in, i_fifo_full, i_fifo_empty, i_soft_reset,
      output o_busy, o_detect_add, o_lfd_state, o_ld_state, o_laf_state, o_full_state,
             o_write_enb_reg, o_rst_int_reg, o_drop_state, o_dest_sel, o_timeout_err
   );
endinterface

// File: rtl/router_wait_timer.sv
// router_wait_timer: bounded wait counter for WAIT_TILL_EMPTY
//   i_clock/i_reset clock and synchronous active-high reset
//   i_clear         zero the count
//   i_enable        advance the count
//   o_expire        count reached WAIT_TIMEOUT-1 (always 0 when WAIT_TIMEOUT=0)
module router_wait_timer
   import router_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 32
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);
   localparam int CW = clog2(WAIT_TIMEOUT + 1) > 0 ? clog2(WAIT_TIMEOUT + 1) : 1;

   logic [CW-1:0] r_cnt;

   assign o_expire = (WAIT_TIMEOUT > 0) && (r_cnt == CW'(WAIT_TIMEOUT - 1));

   // holds at the expire value so the count can never wrap
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear)
         r_cnt <= '0;
      else if (i_enable && !o_expire && WAIT_TIMEOUT > 0)
         r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: 1xN router controller sequencing header decode, payload, parity, full stalls and drops
//   i_clock  system clock
//   i_reset  synchronous active-high reset
//   bus      router_fsm_nch_if slave: datapath inputs, state flags, dest_sel, timeout_err
module router_fsm_nch
   import router_pkg::*;
#(
   parameter int NUM_CH       = 3,
   parameter int ADDR_W       = 2,
   parameter int WAIT_TIMEOUT = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   router_fsm_nch_if.slave  bus
);
   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_dest_sel;
   logic              r_timeout_err;
   logic              w_timeout;
   logic              w_expire;
   logic              w_addr_ok;
   logic              w_empty_in;
   logic              w_empty_sel;
   logic              w_sr_sel;

   // channel lookups by matching, so out-of-range addresses read as 0 instead of indexing past the vector
   always_comb begin
      w_empty_in  = 1'b0;
      w_empty_sel = 1'b0;
      w_sr_sel    = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (bus.i_data_in == ADDR_W'(k))
            w_empty_in = bus.i_fifo_empty[k];
         if (r_dest_sel == ADDR_W'(k)) begin
            w_empty_sel = bus.i_fifo_empty[k];
            w_sr_sel    = bus.i_soft_reset[k];
         end
      end
   end

   assign w_addr_ok = 32'(bus.i_data_in) < 32'(NUM_CH);

   router_wait_timer #(
      .WAIT_TIMEOUT(WAIT_TIMEOUT)
   ) u_timer (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (r_state != WAIT_TILL_EMPTY),
      .i_enable (r_state == WAIT_TILL_EMPTY),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= DECODE_ADDRESS;
         r_dest_sel    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_timeout_err <= w_timeout;
         if (r_state == DECODE_ADDRESS && bus.i_pkt_valid)
            r_dest_sel <= bus.i_data_in;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         DECODE_ADDRESS:
            if (bus.i_pkt_valid)
               w_next = !w_addr_ok ? DROP_PACKET : w_empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         LOAD_FIRST_DATA:
            w_next = LOAD_DATA;
         LOAD_DATA:
            w_next = bus.i_fifo_full ? FIFO_FULL_STATE : !bus.i_pkt_valid ? LOAD_PARITY : LOAD_DATA;
         LOAD_PARITY:
            w_next = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            w_next = bus.i_fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         FIFO_FULL_STATE:
            w_next = bus.i_fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
         LOAD_AFTER_FULL:
            w_next = bus.i_parity_done ? DECODE_ADDRESS : bus.i_low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
         WAIT_TILL_EMPTY:
            // a destination that drains on the expiry cycle still wins over the timeout
            if (w_empty_sel)
               w_next = LOAD_FIRST_DATA;
            else if (w_expire) begin
               w_next    = DROP_PACKET;
               w_timeout = 1'b1;
            end
         DROP_PACKET:
            w_next = bus.i_pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
         default:
            w_next = DECODE_ADDRESS;
      endcase
      // soft reset of the latched destination aborts whatever packet is in flight
      if (r_state != DECODE_ADDRESS && w_sr_sel) begin
         w_next    = DECODE_ADDRESS;
         w_timeout = 1'b0;
      end
   end

   always_comb begin
      bus.o_busy          = !(r_state inside {DECODE_ADDRESS, LOAD_DATA, DROP_PACKET});
      bus.o_detect_add    = r_state == DECODE_ADDRESS;
      bus.o_lfd_state     = r_state == LOAD_FIRST_DATA;
      bus.o_ld_state      = r_state == LOAD_DATA;
      bus.o_laf_state     = r_state == LOAD_AFTER_FULL;
      bus.o_full_state    = r_state == FIFO_FULL_STATE;
      bus.o_write_enb_reg = r_state inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL};
      bus.o_rst_int_reg   = r_state == CHECK_PARITY_ERROR;
      bus.o_drop_state    = r_state == DROP_PACKET;
      bus.o_dest_sel      = r_dest_sel;
      bus.o_timeout_err   = r_timeout_err;
   end
endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised control FSM for the 1xN packet router: decodes the header address, sequences first-data/payload/parity loads into the synchroniser/register path, and stalls on a full destination FIFO. It generalises the 3-channel router controller to NUM_CH outputs. It adds a latched destination, per-destination soft reset, a bounded wait for a busy destination, and dropping of packets with an invalid address or a wait timeout. It sits between the input register block and the FIFO/synchroniser blocks.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_CH
WAIT_TIMEOUT, 32, maximum cycles in WAIT_TILL_EMPTY before the packet is dropped; 0 = wait forever

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pkt_valid  in  1  header/payload valid from source
parity_done  in  1  parity byte captured by register block
low_pkt_valid  in  1  pkt_valid fell while FIFO was full
data_in  in  ADDR_W  address field of the header byte
fifo_full  in  1  selected destination FIFO full
fifo_empty  in  NUM_CH  per-channel FIFO empty
soft_reset  in  NUM_CH  per-channel read-timeout soft reset
busy  out  1  stall source
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
write_enb_reg  out  1  FIFO write enable request
rst_int_reg  out  1  in CHECK_PARITY_ERROR
drop_state  out  1  in DROP_PACKET
dest_sel  out  ADDR_W  latched destination channel
timeout_err  out  1  one-cycle pulse when a wait times out

Behaviour:
- Synchronous reset: state=DECODE_ADDRESS, dest_sel=0, wait counter=0, timeout_err=0. Outputs after reset: detect_add=1, all other outputs 0.
- Moore outputs are decoded combinationally from state:
  - busy=0 in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET; 1 elsewhere.
  - write_enb_reg=1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
- Address capture: in DECODE_ADDRESS with pkt_valid=1, dest_sel <= data_in on that edge. dest_sel holds until the next capture.
- Valid address means data_in < NUM_CH.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid=0 -> stay.
    - Invalid address -> DROP_PACKET.
    - fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
    - Otherwise -> WAIT_TILL_EMPTY.
  - LOAD_FIRST_DATA -> LOAD_DATA.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - Else pkt_valid=0 -> LOAD_PARITY.
    - Else stay.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - FIFO_FULL_STATE: fifo_full -> stay; else -> LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - Else low_pkt_valid -> LOAD_PARITY.
    - Else -> LOAD_DATA.
  - WAIT_TILL_EMPTY:
    - fifo_empty[dest_sel] -> LOAD_FIRST_DATA. Uses the latched dest_sel, never live data_in.
    - Else, if WAIT_TIMEOUT>0 and counter==WAIT_TIMEOUT-1 -> DROP_PACKET, with timeout_err=1 for exactly the following cycle.
    - Else stay and counter+1.
  - DROP_PACKET: pkt_valid=0 -> DECODE_ADDRESS; else stay. Source bytes are discarded; write_enb_reg stays 0.
- Wait counter: width clog2(WAIT_TIMEOUT+1). Cleared on every entry to WAIT_TILL_EMPTY and in every other state. It never wraps.
- Simultaneous fifo_empty[dest_sel] and timeout in the same cycle: empty wins, no timeout_err.
- Soft reset: soft_reset[dest_sel]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS next cycle, overriding all transitions.
  - soft_reset on other channels is ignored.
  - In DECODE_ADDRESS all soft_reset bits are ignored.
  - dest_sel is not cleared.
- Reset mid-packet: reset overrides soft_reset and all transitions; it is effective on the next edge.
- Unused state encodings -> DECODE_ADDRESS.

Decomposition:
- Package router_pkg: state enum (4-bit: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, DROP_PACKET) and the clog2 helper function.
- One sub-module: router_wait_timer, holding the wait counter with clear/enable inputs and an expire output. WAIT_TIMEOUT=0 ties expire to 0.

Test Plan:
- NUM_CH=3; header addr 1, fifo_empty=3'b111, 4 payload bytes then pkt_valid=0 -> state sequence DECODE, LFD, LD x4, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE; dest_sel=1; write_enb_reg high for 5 cycles.
- Header addr 2 with fifo_empty[2]=0 for 10 cycles, then 1 -> WAIT_TILL_EMPTY for 10 cycles, then LFD; timeout_err stays 0; busy=1 throughout the wait.
- WAIT_TIMEOUT=8, fifo_empty[0] held 0 -> DROP_PACKET entered 8 cycles after WAIT; timeout_err=1 for exactly 1 cycle; return to DECODE the cycle after pkt_valid falls.
- Header addr 3 with NUM_CH=3 -> DROP_PACKET; busy=0; write_enb_reg=0; lfd_state never asserted.
- fifo_full asserted mid-payload for 3 cycles, then low_pkt_valid=1 -> LD, FULL x3, LAF, LOAD_PARITY; a second case with parity_done=1 goes LAF -> DECODE.
- In LOAD_DATA with dest_sel=1: soft_reset=3'b100 -> no effect; soft_reset=3'b010 -> DECODE next cycle. reset=1 during LAF -> DECODE, dest_sel=0.
